// File: rtl/filter_mode_pkg.sv
//==============================================================================
// Module      : filter_mode_pkg
// Description : Shared state encoding and default timing constants for the
//               filter-mode sequencer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package filter_mode_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_WAIT_EDGE = 2'd1,
        ST_MUTE      = 2'd2
    } fms_state_t;

    localparam int c_DEBOUNCE_CYCLES_DEFAULT = 125000;
    localparam int c_FLUSH_FRAMES_DEFAULT    = 32;

endpackage : filter_mode_pkg

`default_nettype wire

// File: rtl/switch_debouncer.sv
//==============================================================================
// Module      : switch_debouncer
// Description : Two-stage synchroniser followed by a stability counter that
//               publishes a switch value once it has held long enough.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module switch_debouncer
    import filter_mode_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_sw,
    output logic [WIDTH-1:0] o_debounced
);

    localparam int               c_CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]   r_sync_meta;
    logic [WIDTH-1:0]   r_sync;
    logic [WIDTH-1:0]   r_debounced;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_changed;

    // The value about to enter r_sync differs from the one already there.
    assign w_changed = (r_sync_meta != r_sync);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_meta <= '0;
            r_sync      <= '0;
            r_cnt       <= '0;
            r_debounced <= '0;
        end else begin
            r_sync_meta <= i_sw;
            r_sync      <= r_sync_meta;
            if (w_changed) begin
                r_cnt <= '0;
            end else if (r_cnt != c_CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // At saturation r_sync has been stable, so reloading it is harmless.
            if (r_cnt == c_CNT_MAX) begin
                r_debounced <= r_sync;
            end
        end
    end

    assign o_debounced = r_debounced;

endmodule : switch_debouncer

`default_nettype wire

// File: rtl/filter_mode_sequencer.sv
//==============================================================================
// Module      : filter_mode_sequencer
// Description : Commits debounced FIR mode changes on stereo-frame boundaries
//               and mutes the pass-through stream while the FIR refills.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module filter_mode_sequencer
    import filter_mode_pkg::*;
#(
    parameter int NUMBER_OF_SWITCHES = 4,
    parameter int DATA_WIDTH         = 24,
    parameter int DEBOUNCE_CYCLES    = c_DEBOUNCE_CYCLES_DEFAULT,
    parameter int FLUSH_FRAMES       = c_FLUSH_FRAMES_DEFAULT
) (
    input  logic                          axis_clk,
    input  logic                          reset,
    input  logic [NUMBER_OF_SWITCHES-1:0] sw,
    output logic [NUMBER_OF_SWITCHES-1:0] modes,
    input  logic [DATA_WIDTH-1:0]         s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic                          s_last,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          m_last,
    output logic                          busy
);

    localparam int                  c_FCNT_W     = $clog2(FLUSH_FRAMES + 1);
    localparam logic [c_FCNT_W-1:0] c_FLUSH_LAST = c_FCNT_W'(FLUSH_FRAMES - 1);

    fms_state_t                    r_state;
    fms_state_t                    w_next_state;
    logic [c_FCNT_W-1:0]           r_frame_cnt;
    logic [c_FCNT_W-1:0]           w_frame_cnt_next;
    logic [NUMBER_OF_SWITCHES-1:0] r_modes;
    logic [NUMBER_OF_SWITCHES-1:0] w_modes_next;
    logic                          r_busy;
    logic [NUMBER_OF_SWITCHES-1:0] w_debounced;
    logic                          w_pending;
    logic                          w_boundary;
    logic                          w_mute;

    switch_debouncer #(
        .WIDTH           (NUMBER_OF_SWITCHES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk         (axis_clk),
        .rst         (reset),
        .i_sw        (sw),
        .o_debounced (w_debounced)
    );

    assign w_pending  = (w_debounced != r_modes);
    assign w_boundary = s_valid & m_ready & s_last;

    always_comb begin
        w_next_state     = r_state;
        w_frame_cnt_next = r_frame_cnt;
        w_modes_next     = r_modes;
        case (r_state)
            ST_RUN: begin
                if (w_pending) begin
                    w_next_state = ST_WAIT_EDGE;
                end
            end
            ST_WAIT_EDGE: begin
                if (!w_pending) begin
                    w_next_state = ST_RUN;
                end else if (w_boundary) begin
                    w_next_state     = ST_MUTE;
                    w_modes_next     = w_debounced;
                    w_frame_cnt_next = '0;
                end
            end
            ST_MUTE: begin
                // Output is already silent, so a new mode loads without waiting
                // for a boundary and restarts the flush.
                if (w_pending) begin
                    w_modes_next     = w_debounced;
                    w_frame_cnt_next = '0;
                end else if (w_boundary) begin
                    w_frame_cnt_next = r_frame_cnt + 1'b1;
                    if (r_frame_cnt == c_FLUSH_LAST) begin
                        w_next_state = ST_RUN;
                    end
                end
            end
            default: begin
                w_next_state = ST_MUTE;
            end
        endcase
    end

    always_ff @(posedge axis_clk) begin
        if (reset) begin
            r_state     <= ST_MUTE;
            r_frame_cnt <= '0;
            r_modes     <= '0;
            r_busy      <= 1'b1;
        end else begin
            r_state     <= w_next_state;
            r_frame_cnt <= w_frame_cnt_next;
            r_modes     <= w_modes_next;
            r_busy      <= (w_next_state != ST_RUN);
        end
    end

    assign w_mute  = (r_state == ST_MUTE);
    assign m_data  = w_mute ? '0 : s_data;
    assign m_valid = s_valid;
    assign m_last  = s_last;
    assign s_ready = m_ready;
    assign modes   = r_modes;
    assign busy    = r_busy;

endmodule : filter_mode_sequencer

`default_nettype wire
